// File: rtl/texture_sampler.sv
// Texture read client: (u,v) fixed-point request -> row-major texel address -> registered texel out.
// Define TEXTURE_SAMPLER_CLAMP_EN for clamp addressing; the default build wraps.
module texture_sampler #(
  parameter int TEX_W_LOG2 = 7,
  parameter int TEX_H_LOG2 = 7,
  parameter int FRAC_BITS  = 4,
  parameter int ADDR_W     = 14
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [15:0]       i_u,
  input  logic [15:0]       i_v,
  output logic [ADDR_W-1:0] o_tex_address,
  output logic              o_tex_write_enable,
  input  logic [7:0]        i_tex_data,
  output logic              o_texel_valid,
  input  logic              i_texel_ready,
  output logic [7:0]        o_texel,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_OUT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          texel_q, texel_d;
  logic                accept;

  logic signed [15:0]    tu, tv;
  logic [TEX_W_LOG2-1:0] tu_idx;
  logic [TEX_H_LOG2-1:0] tv_idx;

  // Arithmetic shift floors toward -inf, so fractions truncate the same way for negatives.
  assign tu = $signed(i_u) >>> FRAC_BITS;
  assign tv = $signed(i_v) >>> FRAC_BITS;

`ifdef TEXTURE_SAMPLER_CLAMP_EN
  localparam logic signed [15:0] U_MAX = 16'((1 << TEX_W_LOG2) - 1);
  localparam logic signed [15:0] V_MAX = 16'((1 << TEX_H_LOG2) - 1);

  always_comb begin
    tu_idx = tu[TEX_W_LOG2-1:0];
    if (tu < 0)          tu_idx = '0;
    else if (tu > U_MAX) tu_idx = '1;
    tv_idx = tv[TEX_H_LOG2-1:0];
    if (tv < 0)          tv_idx = '0;
    else if (tv > V_MAX) tv_idx = '1;
  end
`else
  logic unused_hi_bits;
  assign tu_idx = tu[TEX_W_LOG2-1:0];
  assign tv_idx = tv[TEX_H_LOG2-1:0];
  assign unused_hi_bits = ^{tu[15:TEX_W_LOG2], tv[15:TEX_H_LOG2]};
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      texel_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      texel_q <= texel_d;
    end
  end

  assign o_req_ready = !i_reset &&
                       ((state_q == S_IDLE) || ((state_q == S_OUT) && i_texel_ready));
  assign accept      = o_req_ready && i_req_valid;

  // next-state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    texel_d = texel_q;
    if (accept) addr_d = {tv_idx, tu_idx};
    case (state_q)
      S_IDLE:    if (accept) state_d = S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        texel_d = i_tex_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        // Back-to-back: a request taken on the release edge skips IDLE.
        if (i_texel_ready) state_d = accept ? S_FETCH : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    o_tex_address      = addr_q;
    o_tex_write_enable = 1'b0;
    o_texel            = texel_q;
    o_texel_valid      = (state_q == S_OUT);
    o_busy             = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_texture_sampler.sv
// Directed and scoreboarded checks for texture_sampler against a synchronous-read memory model.
module tb_texture_sampler;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [15:0] i_u = '0, i_v = '0;
  logic [13:0] o_tex_address;
  logic        o_tex_write_enable;
  logic [7:0]  i_tex_data = '0;
  logic        o_texel_valid;
  logic        i_texel_ready = 1'b1;
  logic [7:0]  o_texel;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  localparam int N_RND = 1000;
  logic [13:0] sb[$];

  always #5 clk = ~clk;

  texture_sampler dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_u(i_u), .i_v(i_v),
    .o_tex_address(o_tex_address), .o_tex_write_enable(o_tex_write_enable),
    .i_tex_data(i_tex_data),
    .o_texel_valid(o_texel_valid), .i_texel_ready(i_texel_ready),
    .o_texel(o_texel), .o_busy(o_busy)
  );

  function automatic logic [7:0] mem_f(input logic [13:0] a);
    return a[7:0] ^ {a[13:7], 1'b1};
  endfunction

  always @(posedge clk) i_tex_data <= mem_f(o_tex_address);

  // Floor-divide by 16 then wrap/clamp, written independently of bit slicing.
  function automatic int coord(input logic [15:0] c);
    int x;
    int f;
    x = int'($signed(c));
    f = x / 16;
    if (x < 0 && (x % 16) != 0) f = f - 1;
`ifdef TEXTURE_SAMPLER_CLAMP_EN
    if (f < 0) f = 0;
    else if (f > 127) f = 127;
`else
    f = ((f % 128) + 128) % 128;
`endif
    return f;
  endfunction

  function automatic logic [13:0] model_addr(input logic [15:0] u, input logic [15:0] v);
    return 14'(coord(v) * 128 + coord(u));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req_basic(input logic [15:0] u, input logic [15:0] v, input logic [13:0] ea);
    i_u = u; i_v = v; i_req_valid = 1'b1; i_texel_ready = 1'b1;
    #1 chk("rdy_idle", o_req_ready, 1);
    @(negedge clk);
    i_req_valid = 1'b0; i_u = 16'hFFFF; i_v = 16'hFFFF;
    chk("fetch_vld", o_texel_valid, 0);
    chk("fetch_addr", o_tex_address, ea);
    chk("fetch_busy", o_busy, 1);
    @(negedge clk);
    chk("cap_vld", o_texel_valid, 0);
    @(negedge clk);
    chk("out_vld", o_texel_valid, 1);
    chk("out_texel", o_texel, mem_f(ea));
    chk("out_addr", o_tex_address, ea);
    @(negedge clk);
    chk("rdy_back", o_req_ready, 1);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    logic [13:0] wrap_exp;
`ifdef TEXTURE_SAMPLER_CLAMP_EN
    wrap_exp = 14'd16256;
`else
    wrap_exp = 14'd255;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rdy", o_req_ready, 0);
    i_reset = 1'b0;
    chk("rst_vld", o_texel_valid, 0);
    chk("rst_texel", o_texel, 0);
    chk("rst_addr", o_tex_address, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_we", o_tex_write_enable, 0);

    req_basic(16'h0030, 16'h0050, 14'd643);
    req_basic(16'h0037, 16'h0000, 14'd3);
    req_basic(16'hFFF0, 16'h0810, wrap_exp);

    // downstream stall then back-to-back release
    i_u = 16'h0100; i_v = 16'h0020; i_req_valid = 1'b1; i_texel_ready = 1'b0;
    @(negedge clk);
    i_u = 16'h0010; i_v = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_vld", o_texel_valid, 1);
      chk("stall_texel", o_texel, mem_f(14'd272));
      chk("stall_addr", o_tex_address, 14'd272);
      chk("stall_rdy", o_req_ready, 0);
      @(negedge clk);
    end
    i_texel_ready = 1'b1;
    #1 chk("b2b_rdy", o_req_ready, 1);
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("b2b_fetch_vld", o_texel_valid, 0);
    chk("b2b_addr", o_tex_address, 14'd129);
    @(negedge clk);
    chk("b2b_cap_vld", o_texel_valid, 0);
    @(negedge clk);
    chk("b2b_vld", o_texel_valid, 1);
    chk("b2b_texel", o_texel, mem_f(14'd129));
    @(negedge clk);

    // reset while in CAPTURE
    i_u = 16'h0020; i_v = 16'h0030; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    #1 chk("mid_rst_rdy", o_req_ready, 0);
    @(negedge clk);
    i_reset = 1'b0;
    chk("mid_rst_vld", o_texel_valid, 0);
    chk("mid_rst_texel", o_texel, 0);
    chk("mid_rst_addr", o_tex_address, 0);
    chk("mid_rst_busy", o_busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_vld", o_texel_valid, 0);
    end
    req_basic(16'h0030, 16'h0050, 14'd643);

    // random stream with random downstream stalls
    fork
      begin : driver
        for (int i = 0; i < N_RND; i++) begin
          logic [15:0] ru, rv;
          int g;
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin
            i_req_valid = 1'b0;
            @(negedge clk);
          end
          ru = 16'($urandom); rv = 16'($urandom);
          i_u = ru; i_v = rv; i_req_valid = 1'b1;
          g = 0;
          #1;
          while (!o_req_ready && g < 200) begin
            @(negedge clk);
            #1;
            g++;
          end
          if (g >= 200) begin
            chk("drv_timeout", 0, 1);
            break;
          end
          sb.push_back(model_addr(ru, rv));
        end
        @(negedge clk);
        i_req_valid = 1'b0;
      end
      begin : monitor
        int got;
        int cyc;
        logic rdy;
        logic [13:0] ea;
        got = 0;
        cyc = 0;
        while (got < N_RND && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          rdy = ($urandom_range(0, 3) != 0);
          i_texel_ready = rdy;
          if (o_texel_valid && rdy) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
              ea = sb.pop_front();
              chk("rnd_texel", o_texel, mem_f(ea));
              chk("rnd_addr", o_tex_address, ea);
              chk("rnd_we", o_tex_write_enable, 0);
            end
            got++;
          end
        end
        if (got < N_RND) chk("rnd_timeout", got, N_RND);
        i_texel_ready = 1'b1;
      end
    join

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/texture_sampler.md
# texture_sampler

Read-side client of the 128×128 8-bit texture memory. Accepts signed fixed-point (u, v) texture coordinates over a valid/ready handshake and converts them to a row-major texel address. It drives the memory's address port with write-enable held low, captures the texel returned one cycle later, and presents it downstream over a second valid/ready handshake. It sits between the rasterizer's span interpolator and the pixel writer.

## Interface
Parameters:
- TEX_W_LOG2, 7, log2 texture width in texels
- TEX_H_LOG2, 7, log2 texture height in texels
- FRAC_BITS, 4, fractional bits in i_u / i_v
- ADDR_W, 14, memory address width; must equal TEX_W_LOG2+TEX_H_LOG2

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  coordinate request valid
- o_req_ready  out  1  sampler can accept a request this cycle
- i_u  in  16  signed two's-complement u, FRAC_BITS fractional
- i_v  in  16  signed two's-complement v, FRAC_BITS fractional
- o_tex_address  out  ADDR_W  to memory address input
- o_tex_write_enable  out  1  to memory write enable, constant 0
- i_tex_data  in  8  memory read data, valid one cycle after address
- o_texel_valid  out  1  o_texel holds a fetched texel
- i_texel_ready  in  1  downstream accepts texel
- o_texel  out  8  fetched texel (palette index)
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FETCH, CAPTURE, OUT.
- IDLE: o_req_ready=1; on i_req_valid, register address, go to FETCH.
- FETCH: address stable on o_tex_address; memory samples it at end of cycle; go to CAPTURE.
- CAPTURE: o_texel <= i_tex_data; go to OUT.
- OUT: o_texel_valid=1; o_texel and o_tex_address held until i_texel_ready.
  - i_texel_ready with no i_req_valid: back to IDLE.
  - i_texel_ready with i_req_valid: o_req_ready=1 this cycle, new request accepted, go directly to FETCH (back-to-back).
- o_req_ready = (IDLE) | (OUT & i_texel_ready); forced 0 while i_reset high.
- Address: tu = i_u >>> FRAC_BITS, tv = i_v >>> FRAC_BITS (arithmetic shift, integer part); o_tex_address = {tv[TEX_H_LOG2-1:0], tu[TEX_W_LOG2-1:0]} (row-major, v*W+u).
- Default addressing is wrap: integer part taken modulo width/height, so negative coordinates wrap naturally (tu=-1 -> 127).
- Fractional bits are discarded (point sampling, truncation toward −∞).
- Inputs i_u/i_v sampled only on the accept edge; changes afterwards are ignored.

## Timing
- Reset values: state IDLE, o_texel_valid 0, o_texel 8'h00, o_tex_address 0, o_busy 0, o_tex_write_enable 0.
- Accept at edge of cycle N -> FETCH in N+1 -> CAPTURE in N+2 -> o_texel_valid high in cycle N+3.
- Sustained throughput with i_texel_ready held high: one texel every 3 cycles.
- o_texel stable and o_texel_valid held for the whole stall when i_texel_ready is low; no request is accepted during the stall.
- Reset mid-operation (any state): aborts the in-flight fetch next edge, no texel is delivered, all outputs return to reset values.

## Configuration
- TEXTURE_SAMPLER_CLAMP_EN defined: clamp addressing. Integer part <0 -> 0; integer part ≥ width/height -> width-1/height-1; in range -> unchanged. Clamp computed on the full shifted value before truncation.
- Undefined: wrap addressing as in Operation. Latency identical in both builds.

## Test plan
- Reset, then u=16'h0030 (3.0), v=16'h0050 (5.0), ready=1 -> o_tex_address 14'd643, o_texel = mem[643] with valid exactly 3 cycles after accept, o_req_ready back to 1.
- u=16'h0037 (3.4375), v=16'h0000 -> address 3 (fraction truncated).
- u=16'hFFF0 (−1.0), v=16'h0810 (129.0): wrap build -> address 14'd255 (row 1, col 127); clamp build -> address 14'd16256 (row 127, col 0).
- Hold i_texel_ready=0 for 5 cycles in OUT -> o_texel/o_texel_valid stable, o_req_ready=0; release with i_req_valid=1 -> new request accepted same cycle, next texel valid 3 cycles later.
- Assert i_reset in CAPTURE -> o_texel_valid never rises, outputs at reset values next cycle, subsequent request completes normally.
- Random 1000-request stream with random downstream stalls -> texels match scoreboard model in order, o_tex_write_enable never 1.
